// File: rtl/ceespu_sprite_loader.sv
// rtl/ceespu_sprite_loader.sv - walks the sprite attribute table on vblank and writes each word to its sprite unit
module ceespu_sprite_loader #(
    parameter int NUM_SPRITES = 8,
    parameter int ADDR_W      = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vblank_start,
    input  logic [ADDR_W-1:0]      table_base,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic [NUM_SPRITES-1:0] sprite_update,
    output logic [31:0]            sprite_data,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  next_idx;

    assign next_idx = idx + IDX_W'(1);

    // Every output is a register; the request address is precomputed on entry to REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            base_q        <= '0;
            idx           <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            sprite_update <= '0;
            sprite_data   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            sprite_update <= '0;
            done          <= 1'b0;
            overrun       <= vblank_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (vblank_start) begin
                        base_q   <= table_base;
                        idx      <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= table_base;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        sprite_data   <= mem_rdata;
                        mem_req       <= 1'b0;
                        sprite_update <= NUM_SPRITES'(1) << idx;
                        done          <= (idx == LAST_IDX);
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx      <= next_idx;
                        mem_req  <= 1'b1;
                        mem_addr <= base_q + ADDR_W'(next_idx);
                        state    <= REQ;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceespu_sprite_loader.sv
// tb/tb_ceespu_sprite_loader.sv - randomized self-checking bench for ceespu_sprite_loader
module tb_ceespu_sprite_loader;

    localparam int N  = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vblank_start = 1'b0;
    logic [AW-1:0] table_base = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic [N-1:0]  sprite_update;
    logic [31:0]   sprite_data;
    logic          busy;
    logic          done;
    logic          overrun;

    ceespu_sprite_loader #(.NUM_SPRITES(N), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vblank_start (vblank_start),
        .table_base   (table_base),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .sprite_update(sprite_update),
        .sprite_data  (sprite_data),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_data = '0;
    bit          ovr_pending = 1'b0;
    int          busy_cnt = 0;

    always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] addr, input logic [31:0] salt);
        if (salt == 32'd0) return 32'hA000_0000 + {20'h0, addr};
        return salt ^ ({20'h0, addr} * 32'h9E37_79B1);
    endfunction

    // Advance one cycle; overrun must follow a vblank seen while a load was active.
    task automatic tick(input bit in_load);
        ovr_pending = vblank_start && in_load;
        @(negedge clk);
        mem_ack      = 1'b0;
        vblank_start = 1'b0;
        check("overrun", {31'h0, overrun}, {31'h0, ovr_pending});
    endtask

    task automatic idle_gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("idle_busy", {31'h0, busy}, 32'd0);
            check("idle_req", {31'h0, mem_req}, 32'd0);
            check("idle_upd", {24'h0, sprite_update}, 32'd0);
            check("idle_data", sprite_data, last_data);
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            tick(1'b0);
        end
        check("idle_data_end", sprite_data, last_data);
    endtask

    task automatic run_load(input logic [AW-1:0] base, input logic [31:0] salt,
                            input int minw, input int maxw, input int ovr_k,
                            input int abort_k, input bit stray);
        int            waits;
        int            w;
        int            b0;
        logic [AW-1:0] a;
        waits = 0;
        #1 b0 = busy_cnt;
        vblank_start = 1'b1;
        table_base   = base;
        tick(1'b0);
        table_base = AW'($urandom);
        for (int k = 0; k < N; k++) begin
            a = base + AW'(k);
            w = $urandom_range(maxw, minw);
            for (int j = 0; j <= w; j++) begin
                check("req", {31'h0, mem_req}, 32'd1);
                check("addr", {20'h0, mem_addr}, {20'h0, a});
                check("busy_req", {31'h0, busy}, 32'd1);
                check("upd_req", {24'h0, sprite_update}, 32'd0);
                check("done_req", {31'h0, done}, 32'd0);
                check("data_hold", sprite_data, last_data);
                if (k == abort_k) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(a, salt);
                    #1 rst_n = 1'b0;
                    #1;
                    check("rst_req", {31'h0, mem_req}, 32'd0);
                    check("rst_addr", {20'h0, mem_addr}, 32'd0);
                    check("rst_upd", {24'h0, sprite_update}, 32'd0);
                    check("rst_data", sprite_data, 32'd0);
                    check("rst_busy", {31'h0, busy}, 32'd0);
                    check("rst_done", {31'h0, done}, 32'd0);
                    check("rst_ovr", {31'h0, overrun}, 32'd0);
                    last_data = '0;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    rst_n   = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        check("post_rst_upd", {24'h0, sprite_update}, 32'd0);
                        check("post_rst_busy", {31'h0, busy}, 32'd0);
                        check("post_rst_data", sprite_data, 32'd0);
                        tick(1'b0);
                    end
                    return;
                end
                if (j == w) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(a, salt);
                end else begin
                    mem_rdata = $urandom;
                end
                if (k == ovr_k && j == 0) begin
                    vblank_start = 1'b1;
                    table_base   = AW'($urandom);
                end
                tick(1'b1);
            end
            waits += w;
            last_data = mem_word(a, salt);
            check("upd", {24'h0, sprite_update}, 32'd1 << k);
            check("wdata", sprite_data, last_data);
            check("done", {31'h0, done}, (k == N - 1) ? 32'd1 : 32'd0);
            check("req_write", {31'h0, mem_req}, 32'd0);
            check("busy_write", {31'h0, busy}, 32'd1);
            if (stray) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
            tick(1'b1);
        end
        check("end_busy", {31'h0, busy}, 32'd0);
        check("end_done", {31'h0, done}, 32'd0);
        check("end_req", {31'h0, mem_req}, 32'd0);
        check("end_upd", {24'h0, sprite_update}, 32'd0);
        #1 check("busy_cycles", busy_cnt - b0, 2 * N + waits);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req0", {31'h0, mem_req}, 32'd0);
        check("rst_addr0", {20'h0, mem_addr}, 32'd0);
        check("rst_upd0", {24'h0, sprite_update}, 32'd0);
        check("rst_data0", sprite_data, 32'd0);
        check("rst_busy0", {31'h0, busy}, 32'd0);
        check("rst_done0", {31'h0, done}, 32'd0);
        check("rst_ovr0", {31'h0, overrun}, 32'd0);
        rst_n = 1'b1;
        tick(1'b0);

        run_load(12'h100, 32'd0, 0, 0, -1, -1, 1'b0);
        idle_gap(5);
        run_load(12'h100, 32'd0, 3, 3, -1, -1, 1'b0);
        idle_gap(2);
        run_load(12'hFFE, 32'h1234_5678, 0, 1, -1, -1, 1'b1);
        idle_gap(2);
        run_load(12'h200, 32'h0BAD_F00D, 0, 2, 3, -1, 1'b0);
        idle_gap(2);
        run_load(12'h300, 32'hCAFE_0001, 0, 1, -1, 5, 1'b0);
        run_load(12'h340, 32'hCAFE_0002, 0, 0, -1, -1, 1'b0);
        run_load(12'h380, 32'hCAFE_0003, 0, 0, -1, -1, 1'b1);
        run_load(12'h3C0, 32'hCAFE_0004, 0, 2, 7, -1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            run_load(AW'($urandom), $urandom | 32'd1, 0, 3,
                     ($urandom_range(1, 0) == 1) ? int'($urandom_range(N - 1, 0)) : -1,
                     -1, 1'($urandom));
            idle_gap(int'($urandom_range(2, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
